// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg : shared types and default widths for the data-memory arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage : dmem_arb_pkg

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-requester round-robin grant, one-hot output
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // On contention the requester that did not win last time is favoured.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-port round-robin arbiter onto a single-port data memory
// Optional misaligned-access checking: define DMEM_ARB_ALIGN_CHK_EN
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last_gnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_id;
    logic [1:0]          w_gnt;
    logic                w_hs;
    logic                w_misaligned;
    logic [DATA_W-1:0]   w_rsp_data;

    rr_arb2 u_rr_arb2 (
        .req      ({req1_valid, req0_valid}),
        .last_gnt (r_last_gnt),
        .gnt      (w_gnt)
    );

    assign req0_ready = (r_state == IDLE) && w_gnt[0];
    assign req1_ready = (r_state == IDLE) && w_gnt[1];
    assign w_hs       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign w_misaligned = |r_addr[1:0];
`else
    assign w_misaligned = 1'b0;
`endif

    assign mem_a      = r_addr;
    assign mem_wd     = r_wdata;
    assign mem_we     = (r_state == ACCESS) && r_we && !w_misaligned;
    assign w_rsp_data = (w_misaligned || r_we) ? '0 : mem_rd;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_last_gnt <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_id       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_last_gnt <= w_gnt[1];
                r_id       <= w_gnt[1];
                r_we       <= w_gnt[1] ? req1_we    : req0_we;
                r_addr     <= w_gnt[1] ? req1_addr  : req0_addr;
                r_wdata    <= w_gnt[1] ? req1_wdata : req0_wdata;
            end
        end
    end

    // Response is captured as ACCESS ends; each requester keeps its last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_err   <= 1'b0;
        end else begin
            rsp0_valid <= (r_state == ACCESS) && !r_id;
            rsp1_valid <= (r_state == ACCESS) &&  r_id;
            if (r_state == ACCESS) begin
                if (r_id) begin
                    rsp1_rdata <= w_rsp_data;
                    rsp1_err   <= w_misaligned;
                end else begin
                    rsp0_rdata <= w_rsp_data;
                    rsp0_err   <= w_misaligned;
                end
            end
        end
    end

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : scoreboard bench for dmem_arbiter with a behavioural memory
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Environment memory: combinational read, clocked write, word-indexed.
    logic [31:0] mem [16];
    assign mem_rd = mem[mem_a[5:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[5:2]] <= mem_wd;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        bit          id;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
        bit          commit;
        int          widx;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sbq[$];
    bit          grant_log[$];
    logic [31:0] ref_mem [16];
    int          cyc = 0;
    int          pend_we_cycle = -10;
    int          we_cnt = 0;
    int          rsp1_cnt = 0;

    always @(posedge clk) cyc++;

    // Monitor: response checks first, then new handshakes enter the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        bit   id, mis, we;
        logic [31:0] addr, wd;
        if (!rst_n) begin
            sbq.delete();
            pend_we_cycle = -10;
        end else begin
            chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
            chk("mem_we", 32'(mem_we), 32'(cyc == pend_we_cycle));
            if (mem_we) we_cnt++;
            if (rsp1_valid) rsp1_cnt++;
            if (rsp0_valid || rsp1_valid) begin
                if (rsp0_valid && rsp1_valid) chk("dual_rsp", 32'd1, 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e  = sbq.pop_front();
                    id = rsp1_valid;
                    chk("rsp_id", 32'(id), 32'(e.id));
                    chk("rsp_rdata", id ? rsp1_rdata : rsp0_rdata, e.rdata);
                    chk("rsp_err", 32'(id ? rsp1_err : rsp0_err), 32'(e.err));
                    chk("rsp_latency", 32'(cyc - e.cyc), 32'd2);
                    if (e.commit) ref_mem[e.widx] = e.wdata;
                end
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                id   = req1_valid && req1_ready;
                we   = id ? req1_we : req0_we;
                addr = id ? req1_addr : req0_addr;
                wd   = id ? req1_wdata : req0_wdata;
`ifdef DMEM_ARB_ALIGN_CHK_EN
                mis = (addr[1:0] != 2'b00);
`else
                mis = 1'b0;
`endif
                e.id     = id;
                e.err    = mis;
                e.rdata  = (mis || we) ? 32'h0 : ref_mem[addr[5:2]];
                e.cyc    = cyc;
                e.commit = we && !mis;
                e.widx   = int'(addr[5:2]);
                e.wdata  = wd;
                sbq.push_back(e);
                grant_log.push_back(id);
                if (we && !mis) pend_we_cycle = cyc + 1;
            end
        end
    end

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic drive(input bit id, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bit hs = 1'b0;
        int t  = 0;
        if (id) begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end
        while (!hs && t < 50) begin
            @(negedge clk);
            hs = id ? req1_ready : req0_ready;
            t++;
        end
        if (!hs) chk("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain;
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int g0, w0, r0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        #3;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_rsp", {26'd0, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, req0_ready, req1_ready}, 32'd0);
        chk("rst_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Contention straight after reset: expect 0,1,0,1.
        @(posedge clk); #1;
        g0 = grant_log.size();
        fork
            begin drive(1'b0, 1'b1, 32'h10, 32'hA0A0_0001); drive(1'b0, 1'b1, 32'h14, 32'hA0A0_0002); end
            begin drive(1'b1, 1'b0, 32'h10, 32'h0); drive(1'b1, 1'b0, 32'h14, 32'h0); end
        join
        drain();
        chk("grant_count", 32'(grant_log.size() - g0), 32'd4);
        for (int i = 0; i < 4; i++)
            if (g0 + i < grant_log.size())
                chk($sformatf("grant_order%0d", i), 32'(grant_log[g0+i]), 32'(i % 2));

        // Write from req0 then read back from req1.
        @(posedge clk); #1;
        w0 = we_cnt;
        drive(1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF);
        drain();
        chk("write_we_cycles", 32'(we_cnt - w0), 32'd1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h4, 32'h0);
        drain();
        chk("read1_value", rsp1_rdata, 32'hDEAD_BEEF);

        // req0-only traffic must never pulse rsp1.
        @(posedge clk); #1;
        r0 = rsp1_cnt;
        drive(1'b0, 1'b1, 32'h8, 32'h1234_5678);
        drive(1'b0, 1'b0, 32'h8, 32'h0);
        drain();
        chk("read0_value", rsp0_rdata, 32'h1234_5678);
        chk("rsp1_quiet", 32'(rsp1_cnt - r0), 32'd0);

        // Misaligned write; follow with an aligned read of the same word.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h6, 32'hA5A5_A5A5);
        drive(1'b0, 1'b0, 32'h4, 32'h0);
        drain();

        // Reset in the middle of a write access.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'hC, 32'h1111_2222);
        drain();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'hC, 32'hFFFF_FFFF);
        chk("pre_rst_mem_we", 32'(mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_we", 32'(mem_we), 32'd0);
        chk("async_rst_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        drain();
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'hC, 32'h0);
        drain();
        chk("after_rst_read", rsp0_rdata, 32'h1111_2222);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule : tb_dmem_arbiter

`default_nettype wire
